// File: rtl/event_recorder.sv
// rtl/event_recorder.sv - timestamps event pulses, arbitrates round-robin, queues records in a show-ahead FIFO
module event_recorder #(
  parameter int NUM_SRC    = 4,
  parameter int TS_WIDTH   = 32,
  parameter int DEPTH      = 16,
  parameter int CODE_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SRC-1:0]            ev_valid,
  input  logic [3*NUM_SRC-1:0]          ev_level,
  input  logic [CODE_WIDTH*NUM_SRC-1:0] ev_code,
  output logic                          rec_valid,
  input  logic                          rec_ready,
  output logic [TS_WIDTH-1:0]           rec_ts,
  output logic [3:0]                    rec_src,
  output logic [2:0]                    rec_level,
  output logic [CODE_WIDTH-1:0]         rec_code,
  output logic [15:0]                   rec_dropped,
  output logic                          overflow,
  output logic [$clog2(DEPTH):0]        fill
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int RW = TS_WIDTH + 4 + 3 + CODE_WIDTH + 16;

  logic [TS_WIDTH-1:0]   ts;
  logic [NUM_SRC-1:0]    hold_v;
  logic [TS_WIDTH-1:0]   hold_ts   [NUM_SRC];
  logic [2:0]            hold_lvl  [NUM_SRC];
  logic [CODE_WIDTH-1:0] hold_code [NUM_SRC];
  logic [PW-1:0]         ptr;
  logic [15:0]           drop_cnt;

  logic [RW-1:0]         mem [DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [RW-1:0]         head;

  logic                  pop, can_push, gnt_v;
  logic [PW-1:0]         gnt_idx;
  logic [NUM_SRC-1:0]    gnt_vec, drop_vec;
  logic [4:0]            n_drop;
  logic [16:0]           drop_sum;
  logic [15:0]           drop_next;
  logic [RW-1:0]         wdata;
  int                    j;

  assign rec_valid = (fill != '0);
  assign pop       = rec_valid && rec_ready;
  assign can_push  = (fill != (AW+1)'(DEPTH)) || pop;

  // Scan from ptr upward with wrap; the first occupied holding register wins.
  always_comb begin
    gnt_v   = 1'b0;
    gnt_idx = '0;
    j       = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_SRC) j = j - NUM_SRC;
      if (!gnt_v && can_push && hold_v[j]) begin
        gnt_v   = 1'b1;
        gnt_idx = PW'(j);
      end
    end
  end

  always_comb begin
    gnt_vec  = gnt_v ? (NUM_SRC'(1) << gnt_idx) : '0;
    drop_vec = ev_valid & hold_v & ~gnt_vec;
    n_drop   = '0;
    for (int i = 0; i < NUM_SRC; i++) n_drop = n_drop + 5'(drop_vec[i]);
    drop_sum  = (gnt_v ? 17'd0 : {1'b0, drop_cnt}) + 17'(n_drop);
    drop_next = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    wdata     = {hold_ts[gnt_idx], 4'(gnt_idx), hold_lvl[gnt_idx], hold_code[gnt_idx], drop_cnt};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ts       <= '0;
      hold_v   <= '0;
      ptr      <= '0;
      drop_cnt <= '0;
      overflow <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fill     <= '0;
    end else begin
      ts       <= ts + 1'b1;
      drop_cnt <= drop_next;
      if (n_drop != '0) overflow <= 1'b1;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (ev_valid[i] && (!hold_v[i] || gnt_vec[i])) hold_v[i] <= 1'b1;
        else if (gnt_vec[i])                            hold_v[i] <= 1'b0;
      end
      if (gnt_v) begin
        ptr    <= (gnt_idx == PW'(NUM_SRC-1)) ? '0 : gnt_idx + 1'b1;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({gnt_v, pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
    end
  end

  // Payload storage carries no reset; validity is tracked by hold_v and fill.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (ev_valid[i] && (!hold_v[i] || gnt_vec[i])) begin
        hold_ts[i]   <= ts;
        hold_lvl[i]  <= (ev_level[3*i +: 3] > 3'd5) ? 3'd2 : ev_level[3*i +: 3];
        hold_code[i] <= ev_code[CODE_WIDTH*i +: CODE_WIDTH];
      end
    end
    if (gnt_v && !rst) mem[wr_ptr] <= wdata;
  end

  assign head        = rec_valid ? mem[rd_ptr] : '0;
  assign rec_dropped = head[15:0];
  assign rec_code    = head[16 +: CODE_WIDTH];
  assign rec_level   = head[16+CODE_WIDTH +: 3];
  assign rec_src     = head[19+CODE_WIDTH +: 4];
  assign rec_ts      = head[23+CODE_WIDTH +: TS_WIDTH];

endmodule

// File: doc/event_recorder.md
Name: event_recorder

Overview:
- Synthesizable capture stage that sits directly upstream of the testbench event logger.
- Timestamps single-cycle event pulses from up to NUM_SRC hardware checkers, such as in-fabric monitor and stabilize probes.
- Arbitrates those events round-robin and queues them as records in a FIFO.
- Exposes a valid/ready record stream that the bench drains and writes to the log file via the capture path.
- Drops are counted and reported, never silently lost.

Parameters:
NUM_SRC, 4, number of event sources (1..16)
TS_WIDTH, 32, timestamp counter width
DEPTH, 16, record FIFO depth; power of two, >= 2
CODE_WIDTH, 8, per-event topic/subject code width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
ev_valid  in  NUM_SRC  per-source event strobe, one event per high cycle
ev_level  in  3*NUM_SRC  per-source log level: 0 TRACE, 1 DEBUG, 2 INFO, 3 WARN, 4 ERROR, 5 FATAL; 6/7 stored as 2
ev_code  in  CODE_WIDTH*NUM_SRC  per-source event code
rec_valid  out  1  FIFO head holds a record
rec_ready  in  1  consumer accepts head
rec_ts  out  TS_WIDTH  timestamp of head record
rec_src  out  4  source index of head record
rec_level  out  3  level of head record
rec_code  out  CODE_WIDTH  code of head record
rec_dropped  out  16  events dropped immediately before this record was enqueued
overflow  out  1  sticky: any drop since reset
fill  out  clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
Reset and clocking:
- Single clock clk. rst is synchronous and active-high.
- Reset state: all outputs 0; FIFO empty; holding registers empty; arbiter pointer 0; timestamp counter 0; drop counter 0; overflow 0.
- rst asserted mid-operation discards all queued and held records on that edge. No partial record is emitted.

Timestamp:
- Free-running counter, reads 0 in the first cycle after rst deasserts.
- Increments every cycle and wraps modulo 2^TS_WIDTH with no flag.

Stage 1, per-source holding register (1 entry per source):
- On edge where ev_valid[i]=1 and hold[i] is empty or granted this cycle: latch ts, level, code.
- On edge where ev_valid[i]=1 and hold[i] is occupied and not granted: drop the event.
  - Increment the drop counter, saturating at 65535.
  - Set overflow.
- Several sources dropping in the same cycle add their count; the result still saturates.

Stage 2, arbitration and enqueue:
- Grant candidates: occupied holding registers.
- Grant goes to the lowest index >= ptr, wrapping. One grant per cycle at most.
- After a grant, ptr = (grant+1) mod NUM_SRC. ptr is unchanged if nothing is granted.
- A grant occurs only when the FIFO can accept a write: fill<DEPTH, or fill==DEPTH with a pop on the same edge.
- On grant, the record is written with rec_dropped = current drop counter. The drop counter clears on the same edge.
- Drops occurring on the grant edge go into the next record.

Latency:
- ev_valid high in cycle t, FIFO empty, no contention: record visible at the FIFO head with rec_valid=1 in cycle t+2.
- rec_ts equals the counter value in cycle t.

Stage 3, FIFO:
- Show-ahead: rec_valid = (fill!=0); head fields are stable while rec_valid=1 and rec_ready=0.
- Pop on the edge where rec_valid and rec_ready are both 1.
- Simultaneous push and pop:
  - Allowed at any fill, including full.
  - fill is unchanged.
  - When empty, push only; the pop is ignored because rec_valid=0.
- Pointers wrap modulo DEPTH.
- fill updates on the same edge as push/pop.

Ordering:
- Records from one source leave in event order.
- Cross-source order follows grant order, not timestamp order.

Test Plan:
- Single event: reset, ev_valid[2]=1 in cycle 5 with level 4, code 8'hA5, rec_ready=1 -> rec_valid=1 in cycle 7 only; rec_ts=5, rec_src=2, rec_level=4, rec_code=A5, rec_dropped=0.
- Round-robin: all 4 sources pulse in the same cycle, rec_ready=1 -> four records with src order 0,1,2,3 and identical rec_ts; repeat immediately -> order 0,1,2,3 again (ptr back to 0).
- Backpressure/full:
  - rec_ready=0, source 0 pulses every other cycle, 20 times -> fill saturates at 16 and one more event sits in hold[0].
  - Further pulses drop; overflow=1.
  - Raise rec_ready -> first 16 records have rec_dropped=0; the next record carries rec_dropped equal to the count of pulses lost (3); all records are in order.
- Full with simultaneous pop: fill=16, hold[1] occupied, rec_ready=1 for one cycle -> fill stays 16 and src 1's record is written on that edge.
- Drop saturation: hold source 0 blocked (FIFO full) for 70000 pulses -> next source-0 record has rec_dropped=65535.
- Reset mid-stream: fill=9, three holds occupied, assert rst one cycle -> next cycle rec_valid=0, fill=0, overflow=0, counter restarts at 0; fresh event in cycle 1 gets rec_ts=1.
